// File: rtl/noc_link_fifo.sv
// Elastic DEPTH-entry link buffer between an upstream router output and a node input port.
// Optional upstream-stall counter enabled by defining NOC_FIFO_STALL_CNT_EN.
module noc_link_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        up_addr,
  input  logic [DATA_W-1:0]        up_data,
  input  logic                     up_valid,
  output logic                     up_ack,
  output logic [ADDR_W-1:0]        dn_addr,
  output logic [DATA_W-1:0]        dn_data,
  output logic                     dn_valid,
  input  logic                     dn_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;

  // Full is judged on the pre-edge count, so a same-edge pop never frees room for a push.
  assign push = up_valid && !up_ack && (count < FULL);
  assign pop  = dn_ack && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= up_addr;
      mem_data[wr_ptr] <= up_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      up_ack <= 1'b0;
    end else begin
      up_ack <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    dn_valid = (count != '0);
    dn_addr  = '0;
    dn_data  = '0;
    if (dn_valid) begin
      dn_addr = mem_addr[rd_ptr];
      dn_data = mem_data[rd_ptr];
    end
  end

`ifdef NOC_FIFO_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (up_valid && !up_ack && (count == FULL) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_link_fifo.sv
// Randomized and directed bench for noc_link_fifo against a queue-based reference model.
module tb_noc_link_fifo;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef NOC_FIFO_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] up_addr;
  logic [DATA_W-1:0] up_data;
  logic              up_valid;
  logic              up_ack;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              dn_valid;
  logic              dn_ack;
  logic [2:0]        count;
  logic [15:0]       stall_cnt;

  noc_link_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .up_addr(up_addr), .up_data(up_data), .up_valid(up_valid), .up_ack(up_ack),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_valid(dn_valid), .dn_ack(dn_ack),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] q[$];
  bit   m_ack;
  int   m_stall;
  logic [DATA_W-1:0] seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ack   = 1'b0;
    m_stall = 0;
  endtask

  // Advance the reference by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit do_push, do_pop;
    if (rst) begin
      model_clear();
      return;
    end
    do_push = up_valid && !m_ack && (q.size() < DEPTH);
    do_pop  = dn_ack && (q.size() != 0);
    if (STALL_EN && up_valid && !m_ack && q.size() == DEPTH && m_stall < 65535) m_stall++;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back({up_addr, up_data});
    m_ack = do_push;
  endtask

  task automatic compare();
    logic [ADDR_W+DATA_W-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk("dn_valid",  64'(dn_valid),  64'(q.size() != 0));
    chk("dn_addr",   64'(dn_addr),   64'(head[ADDR_W+DATA_W-1:DATA_W]));
    chk("dn_data",   64'(dn_data),   64'(head[DATA_W-1:0]));
    chk("count",     64'(count),     64'(q.size()));
    chk("up_ack",    64'(up_ack),    64'(m_ack));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit v, input int a, input int d);
    up_valid = v;
    up_addr  = ADDR_W'(a);
    up_data  = DATA_W'(d);
  endtask

  initial begin
    bit extra;
    rst = 1'b1; dn_ack = 1'b0;
    drive(0, 0, 0);
    model_clear();
    tick(); tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    rst = 1'b0;

    // Single flit through.
    drive(1, 14, 32'hDEADBEEF);
    tick();
    chk("t1_up_ack", 64'(up_ack), 64'd1);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_dn_addr", 64'(dn_addr), 64'd14);
    chk("t1_dn_data", 64'(dn_data), 64'hDEADBEEF);
    drive(0, 0, 0); dn_ack = 1'b1;
    tick();
    chk("t1_up_ack_low", 64'(up_ack), 64'd0);
    chk("t1_drained", 64'(count), 64'd0);
    chk("t1_dn_valid", 64'(dn_valid), 64'd0);
    dn_ack = 1'b0;

    // Fill to full, then hold flit 5 against a full buffer.
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, k);
      tick();
      drive(0, 0, 0);
      tick();
    end
    chk("t2_full", 64'(count), 64'd4);
    drive(1, 5, 5);
    tick(); tick(); tick();
    chk("t2_no_ack", 64'(up_ack), 64'd0);
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_stall", 64'(stall_cnt), STALL_EN ? 64'd3 : 64'd0);

    // Pop on the same edge as a full-blocked push: no push that edge.
    dn_ack = 1'b1;
    tick();
    chk("t5_count", 64'(count), 64'd3);
    chk("t5_no_ack", 64'(up_ack), 64'd0);
    chk("t5_stall", 64'(stall_cnt), STALL_EN ? 64'd4 : 64'd0);
    dn_ack = 1'b0;
    tick();
    chk("t5_push_next", 64'(up_ack), 64'd1);
    chk("t5_count4", 64'(count), 64'd4);
    chk("t5_head", 64'(dn_data), 64'd2);

    // Async reset with three entries held.
    drive(0, 0, 0); dn_ack = 1'b1;
    tick();
    dn_ack = 1'b0;
    chk("t6_pre", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_dn_valid", 64'(dn_valid), 64'd0);
    chk("t6_dn_data", 64'(dn_data), 64'd0);
    chk("t6_up_ack", 64'(up_ack), 64'd0);
    chk("t6_stall", 64'(stall_cnt), 64'd0);
    tick();
    rst = 1'b0;
    drive(1, 3, 32'h1234);
    tick();
    chk("t6_after", 64'(count), 64'd1);

    // Upstream keeps valid one extra cycle after the ack: one entry only.
    tick();
    chk("t4_count", 64'(count), 64'd1);
    chk("t4_up_ack", 64'(up_ack), 64'd0);
    drive(0, 0, 0); dn_ack = 1'b1;
    tick();
    dn_ack = 1'b0;

    // Ten flits with continuous pops; pointers wrap twice.
    dn_ack = 1'b1;
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1, i, i);
      if (dn_valid) seen.push_back(dn_data);
      tick();
      drive(0, 0, 0);
      if (dn_valid) seen.push_back(dn_data);
      tick();
    end
    if (dn_valid) seen.push_back(dn_data);
    tick();
    chk("t3_n", 64'(seen.size()), 64'd10);
    for (int i = 0; i < 10 && i < seen.size(); i++) chk("t3_seq", 64'(seen[i]), 64'(i));
    dn_ack = 1'b0;

    // Random traffic with varying downstream pressure and optional extra-hold upstream.
    extra = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (up_valid && up_ack) begin
        if ($urandom_range(3) == 0) extra = 1'b1;
        else up_valid = 1'b0;
      end else if (extra) begin
        up_valid = 1'b0;
        extra = 1'b0;
      end else if (!up_valid && $urandom_range(1) == 1) begin
        drive(1, int'($urandom_range(31)), int'($urandom));
      end
      if (c < 1000)      dn_ack = ($urandom_range(4) == 0);
      else if (c < 2000) dn_ack = ($urandom_range(1) == 1);
      else               dn_ack = ($urandom_range(4) != 0);
      if (c == 2500 && $urandom_range(1) == 1) begin
        #3 rst = 1'b1;
        #1 model_clear();
        compare();
        tick();
        rst = 1'b0;
        drive(0, 0, 0);
        extra = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
